// File: rtl/regfile_dump_if.sv
// Debug dump bundle: start/abort control, regfile read port and the (addr, data) beat stream.
interface regfile_dump_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          start_i;
    logic          abort_i;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] radr_o;
    logic [DW-1:0] rdata_i;
    logic          dump_valid_o;
    logic          dump_ready_i;
    logic [AW-1:0] dump_addr_o;
    logic [DW-1:0] dump_data_o;
    logic          dump_last_o;

    modport master (
        input  start_i, abort_i, rdata_i, dump_ready_i,
        output busy_o, done_o, radr_o, dump_valid_o, dump_addr_o, dump_data_o, dump_last_o
    );

    modport slave (
        output start_i, abort_i, rdata_i, dump_ready_i,
        input  busy_o, done_o, radr_o, dump_valid_o, dump_addr_o, dump_data_o, dump_last_o
    );
endinterface

// File: rtl/regfile_dump.sv
// Walks register addresses 0..NREGS-1 on a read-only regfile port and streams each
// (address, data) pair out as one valid/ready beat; abort drops the dump, reset overrides all.
module regfile_dump #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    regfile_dump_if.master  bus
);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    typedef enum logic [1:0] {IDLE, RD, SEND, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          valid_q, valid_d;

    // Next state plus next value of every registered output.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    idx_d   = '0;
                    state_d = RD;
                end
            end
            RD: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else begin
                    addr_d  = idx_q;
                    data_d  = bus.rdata_i;
                    last_d  = (idx_q == LAST_IDX);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (bus.dump_ready_i) begin
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = RD;
                    end
                end
            end
            DONE: state_d = IDLE;
        endcase

        // Beat payload reads zero whenever no beat is presented.
        if (state_d != SEND) begin
            addr_d = '0;
            data_d = '0;
            last_d = 1'b0;
        end

        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        valid_d = (state_d == SEND);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.radr_o       = idx_q;
    assign bus.dump_valid_o = valid_q;
    assign bus.dump_addr_o  = addr_q;
    assign bus.dump_data_o  = data_q;
    assign bus.dump_last_o  = last_q;
endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: a regfile model feeds the read port, each accepted
// start pushes the full expected dump, and a negedge monitor checks every beat and done pulse.
module tb_regfile_dump;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_dump_if #(.AW(AW), .DW(DW)) ifc ();

    regfile_dump #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc.master)
    );

    logic [DW-1:0] regs [NREGS];
    assign ifc.rdata_i = regs[ifc.radr_o];

    beat_t exp_q[$];
    int    ntot = 0;
    int    npass = 0;
    int    beat_cnt = 0;
    int    done_cnt = 0;
    bit    rnd_ready = 1'b0;
    bit    man_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected dump: every register in address order, last flag on the top address.
    function automatic void push_dump();
        beat_t b;
        for (int i = 0; i < int'(NREGS); i++) begin
            b.a = AW'(i);
            b.d = regs[i];
            b.l = (i == int'(NREGS) - 1);
            exp_q.push_back(b);
        end
    endfunction

    // Sole driver of ready; applied late in the cycle so the monitor sees the sampled value.
    always @(posedge clk) begin
        #2;
        ifc.dump_ready_i = rnd_ready ? ($urandom_range(0, 9) < 7) : man_ready;
    end

    // Monitor: beats, payload zeroing, hold stability, done pulses.
    logic  prev_hold = 1'b0;
    beat_t prev_b;
    always @(negedge clk) begin : mon
        beat_t cur;
        beat_t e;
        cur.a = ifc.dump_addr_o;
        cur.d = ifc.dump_data_o;
        cur.l = ifc.dump_last_o;
        if (prev_hold) begin
            chk("hold_valid", 64'(ifc.dump_valid_o), 64'(1));
            chk("hold_beat", 64'(cur), 64'(prev_b));
        end
        if (ifc.dump_valid_o === 1'b0) chk("idle_payload_zero", 64'(cur), 64'(0));
        if (ifc.dump_valid_o && ifc.dump_ready_i && !ifc.abort_i && !rst) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                chk("beat_unexpected", 64'(cur), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("beat", 64'(cur), 64'(e));
            end
        end
        if (ifc.done_o === 1'b1) begin
            done_cnt++;
            chk("done_q_empty", 64'(exp_q.size()), 64'(0));
        end
        prev_hold = (ifc.dump_valid_o === 1'b1) && !ifc.dump_ready_i && !ifc.abort_i && !rst;
        prev_b    = cur;
    end

    task automatic pulse_start(input bit expect_dump);
        @(posedge clk); #1;
        ifc.start_i = 1'b1;
        if (expect_dump) push_dump();
        @(posedge clk); #1;
        ifc.start_i = 1'b0;
    endtask

    task automatic wait_beat(input int a);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk); #1;
            if (ifc.dump_valid_o && ifc.dump_addr_o == AW'(a)) ok = 1'b1;
        end
        if (!ok) chk("wait_beat_timeout", 64'(0), 64'(a + 1));
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (ifc.done_o) ok = 1'b1;
        end
        if (!ok) chk("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_busy"},  64'(ifc.busy_o), 64'(0));
        chk({name, "_done"},  64'(ifc.done_o), 64'(0));
        chk({name, "_valid"}, 64'(ifc.dump_valid_o), 64'(0));
        chk({name, "_radr"},  64'(ifc.radr_o), 64'(0));
        chk({name, "_addr"},  64'(ifc.dump_addr_o), 64'(0));
        chk({name, "_data"},  64'(ifc.dump_data_o), 64'(0));
        chk({name, "_last"},  64'(ifc.dump_last_o), 64'(0));
    endtask

    task automatic randomize_regs();
        for (int i = 0; i < int'(NREGS); i++) regs[i] = $urandom;
    endtask

    initial begin
        int b0;
        int d0;
        rst = 1'b1;
        ifc.start_i = 1'b0;
        ifc.abort_i = 1'b0;
        for (int i = 0; i < int'(NREGS); i++) regs[i] = 32'h0101_0101 * i;

        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", 64'(ifc.busy_o), 64'(0));

        // T1: ready tied high, exact cycle timeline from the start edge.
        man_ready = 1'b1;
        b0 = beat_cnt; d0 = done_cnt;
        pulse_start(1'b1);
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            chk("t1_valid", 64'(ifc.dump_valid_o), 64'((k % 2 == 0) && (k <= 64)));
            chk("t1_done",  64'(ifc.done_o), 64'(k == 65));
            chk("t1_busy",  64'(ifc.busy_o), 64'(k <= 65));
            if ((k % 2 == 1) && (k <= 63)) chk("t1_radr", 64'(ifc.radr_o), 64'((k - 1) / 2));
        end
        chk("t1_beats", 64'(beat_cnt - b0), 64'(NREGS));
        chk("t1_dones", 64'(done_cnt - d0), 64'(1));

        // T2 + T3: stall on beat 5, then a stray start during beat 12.
        b0 = beat_cnt; d0 = done_cnt;
        pulse_start(1'b1);
        wait_beat(5);
        man_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_valid", 64'(ifc.dump_valid_o), 64'(1));
            chk("t2_addr",  64'(ifc.dump_addr_o), 64'(5));
            chk("t2_data",  64'(ifc.dump_data_o), 64'(32'h0505_0505));
            @(posedge clk); #1;
        end
        man_ready = 1'b1;
        for (int i = 0; i < 10 && !(ifc.dump_valid_o && ifc.dump_addr_o != AW'(5)); i++) begin
            @(posedge clk); #1;
        end
        chk("t2_next_addr", 64'(ifc.dump_addr_o), 64'(6));
        wait_beat(12);
        pulse_start(1'b0);
        wait_done(200);
        repeat (4) @(negedge clk);
        chk("t3_beats", 64'(beat_cnt - b0), 64'(NREGS));
        chk("t3_dones", 64'(done_cnt - d0), 64'(1));
        chk("t3_busy",  64'(ifc.busy_o), 64'(0));

        // T4: abort with beat 10 pending, then a clean restart from address 0.
        randomize_regs();
        d0 = done_cnt;
        pulse_start(1'b1);
        wait_beat(10);
        man_ready = 1'b0;
        ifc.abort_i = 1'b1;
        @(posedge clk); #1;
        ifc.abort_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t4_valid", 64'(ifc.dump_valid_o), 64'(0));
        chk("t4_busy",  64'(ifc.busy_o), 64'(0));
        chk("t4_done",  64'(ifc.done_o), 64'(0));
        repeat (3) @(negedge clk);
        chk("t4_no_done", 64'(done_cnt - d0), 64'(0));
        man_ready = 1'b1;
        b0 = beat_cnt;
        pulse_start(1'b1);
        @(posedge clk); #1;
        chk("t4_restart_addr", 64'(ifc.dump_addr_o), 64'(0));
        chk("t4_restart_valid", 64'(ifc.dump_valid_o), 64'(1));
        wait_done(200);
        chk("t4_beats", 64'(beat_cnt - b0), 64'(NREGS));

        // T5: reset in the middle of a dump under random backpressure.
        @(negedge clk);
        randomize_regs();
        rnd_ready = 1'b1;
        pulse_start(1'b1);
        wait_beat(20);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_all_zero("t5");
        rnd_ready = 1'b0;
        b0 = beat_cnt; d0 = done_cnt;
        repeat (6) @(negedge clk);
        chk("t5_idle_busy", 64'(ifc.busy_o), 64'(0));
        chk("t5_no_beats", 64'(beat_cnt - b0), 64'(0));
        chk("t5_no_done", 64'(done_cnt - d0), 64'(0));

        // T6: start and abort together in IDLE do nothing.
        b0 = beat_cnt;
        @(posedge clk); #1;
        ifc.start_i = 1'b1;
        ifc.abort_i = 1'b1;
        @(posedge clk); #1;
        ifc.start_i = 1'b0;
        ifc.abort_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_busy", 64'(ifc.busy_o), 64'(0));
        end
        chk("t6_no_beats", 64'(beat_cnt - b0), 64'(0));

        // Random contents and random backpressure, full dumps.
        for (int n = 0; n < 3; n++) begin
            randomize_regs();
            rnd_ready = 1'b1;
            b0 = beat_cnt; d0 = done_cnt;
            pulse_start(1'b1);
            wait_done(1000);
            rnd_ready = 1'b0;
            repeat (3) @(negedge clk);
            chk("rnd_beats", 64'(beat_cnt - b0), 64'(NREGS));
            chk("rnd_dones", 64'(done_cnt - d0), 64'(1));
            chk("rnd_q_empty", 64'(exp_q.size()), 64'(0));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
